// File: rtl/lut_cascade_pkg.sv
// Shared constants and helpers for the programmable LUT cascade.
// Truth-table slicing and switch-count helpers live here.
package lut_cascade_pkg;

    localparam int LUT_IN       = 4;
    localparam int LUT_W        = 16;
    localparam int SW_PER_STAGE = 3;
    localparam int MAX_STAGES   = 64;

    localparam logic [0:0] CFG_IDLE = 1'b0;
    localparam logic [0:0] CFG_ACK  = 1'b1;

    function automatic int sw_width(input int n);
        return SW_PER_STAGE * n + 1;
    endfunction

    function automatic logic [LUT_W-1:0] lut_slice(
        input logic [LUT_W*MAX_STAGES-1:0] init,
        input int                          k
    );
        return init[k*LUT_W +: LUT_W];
    endfunction

endpackage

// File: rtl/lut_cascade_top_debounce.sv
// Per-switch synchroniser and debouncer.
// The stable level moves only after DB_CYCLES consecutive differing cycles.
module sw_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic stable_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count differing cycles; adopt the synced level on the last one
    always_comb begin
        sync1_d  = sw_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser, counter and stable flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/lut_cascade_top.sv
// Cascade of runtime-programmable 4-input LUT stages driving LEDs.
// Switch inputs are debounced and delay-aligned so each LED sees one snapshot.
module lut_cascade_top
    import lut_cascade_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int DB_CYCLES  = 4,
    parameter logic [LUT_W*NUM_STAGES-1:0] LUT_INIT = 32'h8000FFFE,
    localparam int SW_W = sw_width(NUM_STAGES),
    localparam int CSW  = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SW_W-1:0]       sw,
    output logic [NUM_STAGES-1:0] led,
    output logic                  led_chg,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CSW-1:0]        cfg_stage,
    input  logic [LUT_W-1:0]      cfg_table,
    output logic                  cfg_err
);

    localparam logic [CSW-1:0] STAGE_LIMIT = CSW'(NUM_STAGES);
    localparam logic [LUT_W*MAX_STAGES-1:0] INIT_EXT =
        (LUT_W*MAX_STAGES)'(LUT_INIT);

    logic [SW_W-1:0]       stable;
    logic [LUT_W-1:0]      tbl_q [NUM_STAGES];
    logic [LUT_W-1:0]      tbl_d [NUM_STAGES];
    logic [LUT_IN-1:0]     idx   [NUM_STAGES];
    logic [NUM_STAGES-1:0] y_q, y_d;
    logic                  led_chg_q, led_chg_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [0:0]            state_q, state_d;
    logic                  accept;

    for (genvar i = 0; i < SW_W; i++) begin : g_db
        sw_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_i    (sw[i]),
            .stable_o(stable[i])
        );
    end

    assign idx[0] = stable[LUT_IN-1:0];

    for (genvar k = 1; k < NUM_STAGES; k++) begin : g_dl
        logic [SW_PER_STAGE-1:0] dl_q [k];
        logic [SW_PER_STAGE-1:0] dl_d [k];

        // Shift this stage's switches k cycles to meet y[k-1]
        always_comb begin
            dl_d[0] = stable[SW_PER_STAGE*k+1 +: SW_PER_STAGE];
            for (int j = 1; j < k; j++) begin
                dl_d[j] = dl_q[j-1];
            end
        end

        // Delay line registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dl_q <= '{default: '0};
            end else begin
                dl_q <= dl_d;
            end
        end

        assign idx[k] = {dl_q[k-1], y_q[k-1]};
    end

    assign cfg_ready = (state_q == CFG_IDLE);
    assign accept    = cfg_valid && cfg_ready;

    // Stage evaluation with current tables, table writes and config FSM
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            y_d[k]   = tbl_q[k][idx[k]];
            tbl_d[k] = tbl_q[k];
            if (accept && (cfg_stage == CSW'(k))) begin
                tbl_d[k] = cfg_table;
            end
        end
        led_chg_d = (y_d != y_q);
        cfg_err_d = accept && (cfg_stage >= STAGE_LIMIT);
        state_d   = state_q;
        unique case (state_q)
            CFG_IDLE: state_d = accept ? CFG_ACK : CFG_IDLE;
            CFG_ACK:  state_d = CFG_IDLE;
        endcase
    end

    // Stage outputs, tables and handshake state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                tbl_q[k] <= lut_slice(INIT_EXT, k);
            end
            y_q       <= '0;
            led_chg_q <= 1'b0;
            cfg_err_q <= 1'b0;
            state_q   <= CFG_IDLE;
        end else begin
            tbl_q     <= tbl_d;
            y_q       <= y_d;
            led_chg_q <= led_chg_d;
            cfg_err_q <= cfg_err_d;
            state_q   <= state_d;
        end
    end

    assign led     = y_q;
    assign led_chg = led_chg_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_lut_cascade_top.sv
// Self-checking bench for lut_cascade_top: directed scenarios
// followed by randomized switch and config traffic against a cycle model.
module tb_lut_cascade_top;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int SW = 7;
    localparam logic [31:0] INIT = 32'h8000FFFE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] sw;
    logic [N-1:0]  led;
    logic          led_chg;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_stage;
    logic [15:0]   cfg_table;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;

    lut_cascade_top #(
        .NUM_STAGES(N),
        .DB_CYCLES (DB),
        .LUT_INIT  (INIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .led      (led),
        .led_chg  (led_chg),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_stage(cfg_stage),
        .cfg_table(cfg_table),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0]   m_tbl [N];
    logic [SW-1:0] m_s1, m_s2, m_stab;
    int            m_run [SW];
    logic [SW-1:0] m_past [N];
    logic [N-1:0]  m_led;
    logic          m_chg, m_ready, m_err, m_acc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_tbl[k]  = INIT[16*k +: 16];
            m_past[k] = '0;
        end
        for (int i = 0; i < SW; i++) m_run[i] = 0;
        m_s1 = '0; m_s2 = '0; m_stab = '0;
        m_led = '0; m_chg = 0; m_ready = 1; m_err = 0; m_acc = 0;
    endtask

    task automatic model_edge();
        logic [SW-1:0] cur;
        logic [N-1:0]  nled;
        logic [3:0]    ix;
        cur = m_stab;
        nled[0] = m_tbl[0][cur[3:0]];
        for (int k = 1; k < N; k++) begin
            ix = {m_past[k-1][3*k+1 +: 3], m_led[k-1]};
            nled[k] = m_tbl[k][ix];
        end
        m_chg = (nled != m_led);
        m_led = nled;
        m_acc = m_ready && cfg_valid;
        if (m_acc) begin
            if (cfg_stage < N) m_tbl[cfg_stage] = cfg_table;
            m_err = (cfg_stage >= N);
            m_ready = 0;
        end else begin
            m_err = 0;
            m_ready = 1;
        end
        for (int j = N - 1; j > 0; j--) m_past[j] = m_past[j-1];
        m_past[0] = cur;
        for (int i = 0; i < SW; i++) begin
            if (m_s2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_stab[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = sw;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("led", 32'(led), 32'(m_led));
        chk("led_chg", 32'(led_chg), 32'(m_chg));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic settle(input int n);
        sw = '0;
        repeat (n) step();
    endtask

    task automatic scn1(input string t);
        sw = 7'b0000001;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 6) chk({t, "_led_e6"}, 32'(led), 32'h0);
            if (e == 7) begin
                chk({t, "_led_e7"}, 32'(led), 32'h1);
                chk({t, "_chg_e7"}, 32'(led_chg), 32'h1);
            end
            if (e == 8) begin
                chk({t, "_led_e8"}, 32'(led), 32'h1);
                chk({t, "_chg_e8"}, 32'(led_chg), 32'h0);
            end
        end
    endtask

    task automatic scn3(input string t);
        sw = 7'b1110001;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) begin
                chk({t, "_led_e7"}, 32'(led), 32'h1);
                chk({t, "_chg_e7"}, 32'(led_chg), 32'h1);
            end
            if (e == 8) begin
                chk({t, "_led_e8"}, 32'(led), 32'h3);
                chk({t, "_chg_e8"}, 32'(led_chg), 32'h1);
            end
        end
    endtask

    initial begin
        rst_n = 0; sw = '0;
        cfg_valid = 0; cfg_stage = '0; cfg_table = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_chg", 32'(led_chg), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        chk("rst_err", 32'(cfg_err), 32'h0);
        rst_n = 1;
        settle(3);

        // 1: single switch lights stage 0 only
        scn1("s1");
        settle(12);

        // 2: short bounce is filtered
        sw = 7'b0000001;
        for (int e = 1; e <= 13; e++) begin
            if (e == 4) sw = '0;
            step();
            chk("s2_led", 32'(led), 32'h0);
            chk("s2_chg", 32'(led_chg), 32'h0);
        end

        // 3: aligned snapshot through both stages
        scn3("s3");
        settle(12);

        // 4: program stage 1 as NOR, then back-to-back write
        cfg_valid = 1; cfg_stage = 2'd1; cfg_table = 16'h0001;
        step();
        chk("s4_ready_ack", 32'(cfg_ready), 32'h0);
        cfg_table = 16'h8000;
        step();
        chk("s4_led_nor", 32'(led), 32'h2);
        chk("s4_ready_back", 32'(cfg_ready), 32'h1);
        step();
        chk("s4_ready_2nd", 32'(cfg_ready), 32'h0);
        cfg_valid = 0;
        step();
        chk("s4_led_and", 32'(led), 32'h0);
        settle(3);

        // 5: out-of-range write flags an error, tables intact
        cfg_valid = 1; cfg_stage = 2'd2; cfg_table = 16'hFFFF;
        step();
        chk("s5_err", 32'(cfg_err), 32'h1);
        chk("s5_led", 32'(led), 32'h0);
        cfg_valid = 0;
        step();
        chk("s5_err_end", 32'(cfg_err), 32'h0);
        settle(4);
        scn3("s5r");
        settle(12);

        // 6: reset mid-debounce and mid-ACK
        sw = 7'b0000001;
        repeat (3) step();
        cfg_valid = 1; cfg_stage = 2'd1; cfg_table = 16'h0001;
        step();
        chk("s6_in_ack", 32'(cfg_ready), 32'h0);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("s6_led", 32'(led), 32'h0);
        chk("s6_chg", 32'(led_chg), 32'h0);
        chk("s6_ready", 32'(cfg_ready), 32'h1);
        chk("s6_err", 32'(cfg_err), 32'h0);
        cfg_valid = 0; sw = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        scn1("s6");
        settle(12);
        scn3("s6r");
        settle(12);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) sw = 7'($urandom);
            if (!cfg_valid && $urandom_range(0, 9) == 0) begin
                cfg_valid = 1;
                cfg_stage = 2'($urandom_range(0, 3));
                cfg_table = 16'($urandom);
            end
            step();
            if (m_acc) cfg_valid = 0;
        end
        cfg_valid = 0;
        settle(12);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
